// File: rtl/cmods7_ui_pkg.sv
// cmods7_ui_pkg
//   Shared types and constants for the CmodS7 user-interface controller.
//   - mode_t       : RUN / MENU operating mode
//   - evt_code_t   : event code {btn, is_long}, packs to the 2-bit event bus
//   - cls_state_t  : per-button press classifier states
//   - EVT_DEPTH    : event queue depth, 4 when CMODS7_UI_EVT_FIFO_EN is
//                    defined, otherwise 1 (single holding register)
//   - thermo4()    : 4-segment thermometer of a 0..7 level, clipped at 4
package cmods7_ui_pkg;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_MENU = 1'b1
    } mode_t;

    typedef struct packed {
        logic btn;
        logic is_long;
    } evt_code_t;

    typedef enum logic [1:0] {
        CLS_WAIT_REL = 2'd0,
        CLS_IDLE     = 2'd1,
        CLS_PRESSED  = 2'd2
    } cls_state_t;

`ifdef CMODS7_UI_EVT_FIFO_EN
    localparam int EVT_DEPTH = 4;
`else
    localparam int EVT_DEPTH = 1;
`endif

    function automatic logic [3:0] thermo4(input logic [2:0] level);
        logic [3:0] bar;
        case (level)
            3'd0:    bar = 4'b0000;
            3'd1:    bar = 4'b0001;
            3'd2:    bar = 4'b0011;
            3'd3:    bar = 4'b0111;
            default: bar = 4'b1111;
        endcase
        return bar;
    endfunction

endpackage

// File: rtl/cmods7_btn_class.sv
// cmods7_btn_class
//   Classifies presses of one debounced button as short or long.
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous active-high reset
//     btn_q_i    in   registered button level
//     tick_i     in   1 ms tick, shared between classifiers
//     evt_o      out  one-cycle event strobe
//     evt_long_o out  qualifies evt_o: 1 = long press, 0 = short press
//   Parameter LONG_MS: number of ms ticks that make a press long.
module cmods7_btn_class
    import cmods7_ui_pkg::*;
#(
    parameter int LONG_MS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_q_i,
    input  logic tick_i,
    output logic evt_o,
    output logic evt_long_o
);

    localparam int CW = $clog2(LONG_MS + 1);

    cls_state_t    state_q, state_d;
    logic [CW-1:0] ms_cnt_q, ms_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CLS_WAIT_REL;
            ms_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
        end
    end

    // The event strobe is combinational from the state so that the pending
    // bit in the parent registers on the same edge the classifier moves on.
    // A release in the same cycle as the final tick counts as short.
    always_comb begin
        state_d    = state_q;
        ms_cnt_d   = ms_cnt_q;
        evt_o      = 1'b0;
        evt_long_o = 1'b0;
        case (state_q)
            CLS_WAIT_REL: begin
                if (!btn_q_i) state_d = CLS_IDLE;
            end
            CLS_IDLE: begin
                if (btn_q_i) begin
                    state_d  = CLS_PRESSED;
                    ms_cnt_d = '0;
                end
            end
            CLS_PRESSED: begin
                if (!btn_q_i) begin
                    evt_o   = 1'b1;
                    state_d = CLS_IDLE;
                end else if (tick_i) begin
                    if (ms_cnt_q == CW'(LONG_MS - 1)) begin
                        evt_o      = 1'b1;
                        evt_long_o = 1'b1;
                        state_d    = CLS_WAIT_REL;
                    end else begin
                        ms_cnt_d = ms_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = CLS_WAIT_REL;
        endcase
    end

endmodule

// File: rtl/cmods7_ui_ctrl.sv
// cmods7_ui_ctrl
//   User-side controller for the CmodS7 board: short/long button events,
//   RUN/MENU mode machine, event queue and LED/RGB drive generation.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     btn_i[1:0]               debounced buttons, active high
//     level_i[2:0]             level shown as a bar in RUN
//     busy_i, fault_i          status inputs for the RGB LED
//     evt_valid_o/evt_ready_i  event handshake
//     evt_code_o[1:0]          {button index, long}
//     evt_drop_o[7:0]          saturating dropped-event count
//     mode_o                   0 = RUN, 1 = MENU
//     menu_sel_o[1:0]          menu selection
//     led_o[3:0]               discrete LEDs
//     led0_r_o/g_o/b_o         RGB LED
//   Macro CMODS7_UI_EVT_FIFO_EN: 4-entry event FIFO when defined, single
//   holding register otherwise.
module cmods7_ui_ctrl
    import cmods7_ui_pkg::*;
#(
    parameter int CLK_FREQ = 12_000_000,
    parameter int LONG_MS  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn_i,
    input  logic [2:0] level_i,
    input  logic       busy_i,
    input  logic       fault_i,
    output logic       evt_valid_o,
    input  logic       evt_ready_i,
    output logic [1:0] evt_code_o,
    output logic [7:0] evt_drop_o,
    output logic       mode_o,
    output logic [1:0] menu_sel_o,
    output logic [3:0] led_o,
    output logic       led0_r_o,
    output logic       led0_g_o,
    output logic       led0_b_o
);

    localparam int TICK_DIV  = CLK_FREQ / 1000;
    localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int PW        = $clog2(TICK_DIV + 1);
    localparam int BW        = $clog2(BLINK_DIV + 1);

    logic [1:0]    btn_q;
    logic [PW-1:0] presc_q;
    logic          tick;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_q;
    logic [1:0]    cls_evt, cls_long;
    logic [1:0]    pend_q, pend_d, pend_long_q, pend_long_d;
    logic          svc_valid;
    evt_code_t     svc_code;
    mode_t         mode_q, mode_d;
    logic [1:0]    sel_q, sel_d;
    logic          q_wr, q_push, q_pop, q_drop;
    logic [7:0]    drop_q;
    logic [3:0]    led_q, led_d;
    logic          r_q, g_q, b_q, r_d, g_d, b_d;

    // Button sampler is deliberately left out of reset: a button held through
    // reset must already read as pressed on the first cycle afterwards, so
    // that the classifiers stay in WAIT_REL instead of seeing a fresh press.
    always_ff @(posedge clk) begin
        btn_q <= btn_i;
    end

    // Free-running 1 ms prescaler and blink phase generator.
    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    cmods7_btn_class #(.LONG_MS(LONG_MS)) u_cls0 (
        .clk        (clk),
        .rst        (rst),
        .btn_q_i    (btn_q[0]),
        .tick_i     (tick),
        .evt_o      (cls_evt[0]),
        .evt_long_o (cls_long[0])
    );

    cmods7_btn_class #(.LONG_MS(LONG_MS)) u_cls1 (
        .clk        (clk),
        .rst        (rst),
        .btn_q_i    (btn_q[1]),
        .tick_i     (tick),
        .evt_o      (cls_evt[1]),
        .evt_long_o (cls_long[1])
    );

    // Arbiter: one pending event per cycle, button 0 first. A new classifier
    // event overrides the clear of its own pending bit.
    always_comb begin
        svc_valid        = |pend_q;
        svc_code.btn     = ~pend_q[0];
        svc_code.is_long = pend_q[0] ? pend_long_q[0] : pend_long_q[1];
        pend_d           = pend_q;
        pend_long_d      = pend_long_q;
        if (pend_q[0]) begin
            pend_d[0] = 1'b0;
        end else if (pend_q[1]) begin
            pend_d[1] = 1'b0;
        end
        for (int b = 0; b < 2; b++) begin
            if (cls_evt[b]) begin
                pend_d[b]      = 1'b1;
                pend_long_d[b] = cls_long[b];
            end
        end
    end

    // Router: long button 0 toggles the mode, RUN forwards everything else
    // to the queue, MENU consumes short presses as selection moves.
    always_comb begin
        mode_d = mode_q;
        sel_d  = sel_q;
        q_wr   = 1'b0;
        if (svc_valid) begin
            if (!svc_code.btn && svc_code.is_long) begin
                mode_d = (mode_q == MODE_RUN) ? MODE_MENU : MODE_RUN;
            end else if (mode_q == MODE_RUN) begin
                q_wr = 1'b1;
            end else if (!svc_code.is_long) begin
                sel_d = svc_code.btn ? sel_q + 2'd1 : sel_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            pend_long_q <= '0;
            mode_q      <= MODE_RUN;
            sel_q       <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_long_q <= pend_long_d;
            mode_q      <= mode_d;
            sel_q       <= sel_d;
        end
    end

    // Event queue. A pop frees room for a write in the same cycle, so a
    // full queue only drops when the consumer is not accepting.
    assign q_pop = evt_valid_o & evt_ready_i;

`ifdef CMODS7_UI_EVT_FIFO_EN
    evt_code_t  fifo_q [EVT_DEPTH];
    logic [1:0] rd_ptr_q, wr_ptr_q;
    logic [2:0] cnt_q;
    logic       q_full;

    assign q_full = (cnt_q == 3'(EVT_DEPTH));
    assign q_push = q_wr & (~q_full | q_pop);
    assign q_drop = q_wr & q_full & ~q_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < EVT_DEPTH; i++) fifo_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (q_push) begin
                fifo_q[wr_ptr_q] <= svc_code;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (q_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            cnt_q <= cnt_q + {2'b00, q_push} - {2'b00, q_pop};
        end
    end

    assign evt_valid_o = (cnt_q != 3'd0);
    assign evt_code_o  = fifo_q[rd_ptr_q];
`else
    logic      hold_valid_q;
    evt_code_t hold_code_q;

    assign q_push = q_wr & (~hold_valid_q | q_pop);
    assign q_drop = q_wr & hold_valid_q & ~q_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_code_q  <= '0;
        end else if (q_push) begin
            hold_valid_q <= 1'b1;
            hold_code_q  <= svc_code;
        end else if (q_pop) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign evt_valid_o = hold_valid_q;
    assign evt_code_o  = hold_code_q;
`endif

    // Saturating dropped-event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (q_drop && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    // LED generator: bar graph in RUN, blinking one-hot selection in MENU,
    // RGB by fault > busy > MENU > idle priority.
    always_comb begin
        led_d = (mode_q == MODE_RUN) ? thermo4(level_i)
                                     : ((4'b0001 << sel_q) & {4{blink_q}});
        r_d = 1'b0;
        g_d = 1'b0;
        b_d = 1'b0;
        if (fault_i) begin
            r_d = blink_q;
        end else if (busy_i) begin
            b_d = 1'b1;
        end else if (mode_q == MODE_MENU) begin
            g_d = 1'b1;
            b_d = 1'b1;
        end else begin
            g_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
            r_q   <= 1'b0;
            g_q   <= 1'b0;
            b_q   <= 1'b0;
        end else begin
            led_q <= led_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
        end
    end

    assign evt_drop_o = drop_q;
    assign mode_o     = mode_q;
    assign menu_sel_o = sel_q;
    assign led_o      = led_q;
    assign led0_r_o   = r_q;
    assign led0_g_o   = g_q;
    assign led0_b_o   = b_q;

endmodule

// File: doc/cmods7_ui_ctrl.md
# cmods7_ui_ctrl

User-side counterpart of the CmodS7 board-support block. It consumes the two debounced buttons and classifies each press as short or long. Presses are turned into an event stream and a local RUN/MENU mode machine. It also generates the 4 discrete LED and RGB LED drive that the board-support block PWMs onto the pins.

## Interface
- `CLK_FREQ`, 12_000_000: clock frequency in Hz; must be divisible by 1000.
- `LONG_MS`, 1000: hold time in ms that classifies a press as long.
- `BLINK_HZ`, 2: blink rate for blinking LED patterns.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_i`  in  2  debounced buttons, active high.
- `level_i`  in  3  signal level 0..7, shown as a bar in RUN.
- `busy_i`  in  1  receiver busy status.
- `fault_i`  in  1  fault status.
- `evt_valid_o`  out  1  event available.
- `evt_ready_i`  in  1  consumer accepts event.
- `evt_code_o`  out  2  bit1 = button index, bit0 = long.
- `evt_drop_o`  out  8  saturating count of dropped events.
- `mode_o`  out  1  0 = RUN, 1 = MENU.
- `menu_sel_o`  out  2  menu selection.
- `led_o`  out  4  discrete LED drive.
- `led0_r_o`, `led0_g_o`, `led0_b_o`  out  1 each  RGB drive.

## Operation
- **Sampling:** `btn_i` is registered once (`btn_q`).
- **Timebase:** a free-running prescaler emits a 1 ms tick every `CLK_FREQ/1000` cycles.
- **Per-button classifier states:**
  - WAIT_REL, the reset state: wait for `btn_q` = 0, then go to IDLE. A button held through reset produces no event.
  - IDLE: on `btn_q` = 1, go to PRESSED and clear the ms counter.
  - PRESSED:
    - Count ms ticks.
    - On release before `LONG_MS` ticks, raise a short event and go to IDLE.
    - On reaching `LONG_MS` ticks while held, raise a long event immediately and go to WAIT_REL.
    - Release in WAIT_REL raises nothing.
- **Pending bits and arbitration:**
  - Each classifier event sets a per-button pending bit holding its code.
  - The arbiter services one pending bit per cycle; button 0 has priority when both are pending.
  - Button 1 is serviced on the following cycle.
- **Routing:**
  - Long press on button 0 toggles the mode. It is never forwarded.
  - RUN: all other events are written to the event queue.
  - MENU: events are consumed locally and not forwarded.
    - Short button 1: `menu_sel` + 1 (3 wraps to 0).
    - Short button 0: `menu_sel` − 1 (0 wraps to 3).
    - Long button 1: no effect.
- **Queue:**
  - The queue supplies `evt_valid_o`/`evt_code_o`.
  - A pop happens when `evt_valid_o` and `evt_ready_i` are both high.
  - A write to a full queue is discarded and increments `evt_drop_o`, which saturates at 255.
  - A simultaneous pop and write when full succeeds without a drop.
- **Discrete LEDs:**
  - RUN: `led_o` is a thermometer of `min(level_i, 4)`, e.g. 3 gives 0111.
  - MENU: `led_o` = one-hot(`menu_sel`), gated by the blink phase.
- **RGB priority:**
  1. `fault_i`: red, blinking.
  2. Else `busy_i`: solid blue.
  3. Else MENU: solid green and blue.
  4. Else: solid green.
- **Blink phase:** toggles every `CLK_FREQ/(2*BLINK_HZ)` cycles and starts at 1 after reset.

## Timing
- **Reset values:**
  - `evt_valid_o` = 0, `evt_code_o` = 0, `evt_drop_o` = 0.
  - `mode_o` = RUN, `menu_sel_o` = 0.
  - `led_o` = 0, all RGB outputs = 0.
  - Classifiers in WAIT_REL; queue empty; prescaler and blink counters at 0.
- All outputs are registered; the LED outputs take their first non-reset values on the cycle after reset deasserts.
- **Short-event latency:** with the queue empty and no arbitration conflict, `evt_valid_o` rises exactly 3 cycles after the release edge appears on `btn_i`.
  - Cycle +1: `btn_q`.
  - Cycle +2: classifier and pending bit.
  - Cycle +3: queue.
- **Long-event latency:** the long event follows the same latency, counted from the cycle the `LONG_MS`-th tick is counted.
- **Tick resolution:** long-press timing resolution is one tick, so the actual hold is (`LONG_MS`−1, `LONG_MS`] ms.
- A mode toggle takes effect 3 cycles after it is detected. Events already in the queue remain.
- Assertion of `rst` mid-press or mid-handshake returns everything to reset values on the next clock.

## Configuration
- `CMODS7_UI_EVT_FIFO_EN` defined: the event queue is a 4-entry FIFO.
- Undefined: the event queue is a single holding register, i.e. depth 1.
- Latency and drop semantics are identical in both builds.

## Structure
- **Package `cmods7_ui_pkg`:**
  - `mode_t` enum (RUN, MENU).
  - `evt_code_t` struct {btn, long}.
  - Classifier state enum.
  - `EVT_DEPTH` constant, 4 or 1 per the macro.
- **Sub-module `cmods7_btn_class`:** per-button classifier, parameterised by `LONG_MS`. It is instanced twice, sharing the ms tick.
- The queue, arbiter, mode machine and LED generator are inline.

## Test plan
Bench parameters: `CLK_FREQ`=10_000 (1 ms = 10 cycles), `LONG_MS`=5, `BLINK_HZ`=250 (toggle every 20 cycles).

- Button 0 high 20 cycles, then low, RUN, `evt_ready_i`=1 → one event code 00; `evt_valid_o` high 3 cycles after release for one cycle; no other events.
- Button 1 held 100 cycles → code 11 shortly after the 5th tick; nothing on release.
- Button 0 held 100 cycles → `mode_o`=1, no event. Then 5 short button-1 presses → `menu_sel_o` = 1, 2, 3, 0, 1. `led_o` alternates 0010/0000 every 20 cycles.
- Both buttons released in the same cycle, RUN → code 00, then code 10 in consecutive accepted beats.
- `evt_ready_i`=0 with 6 short presses → the FIFO build holds 4 and reports `evt_drop_o`=2; the register build holds 1 and reports 5. Raising ready drains them in order.
- `btn_i`=01 held across `rst` release → no event until release and re-press. `fault_i`=1 → red toggles every 20 cycles; with fault low and `busy_i`=1 → solid blue. `level_i`=6 in RUN → `led_o`=1111.
